// File: rtl/nibble_pkg.sv
// Shared types and helpers for the nibble serializer.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package nibble_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int NIB_W_DEFAULT = 4;

    // Widest word the selector handles; callers zero-extend into this width.
    localparam int WORD_W_MAX = 64;

    // Pick nibble number idx from word. With lsn_first the count starts at
    // bit 0; otherwise it starts at the top of the word, so the caller
    // left-justifies its word into WORD_W_MAX bits before calling.
    function automatic logic [NIB_W_DEFAULT-1:0] nib_sel(
        input logic [WORD_W_MAX-1:0] word,
        input int unsigned           idx,
        input logic                  lsn_first
    );
        int unsigned sh;
        if (lsn_first) begin
            sh = idx * NIB_W_DEFAULT;
        end else begin
            sh = WORD_W_MAX - NIB_W_DEFAULT - idx * NIB_W_DEFAULT;
        end
        return NIB_W_DEFAULT'(word >> sh);
    endfunction

endpackage

// File: rtl/nibble_serializer.sv
// Splits an IN_W-bit word into IN_W/NIB_W nibbles, LSN or MSN first.
// Latency: nibble 0 valid the cycle after accept; N cycles/word, no bubbles when streaming.
// Backpressure: out_data/out_last/out_valid held while out_ready=0; in_ready only when idle or on last-nibble handshake.
module nibble_serializer
    import nibble_pkg::*;
#(
    parameter int IN_W      = 8,
    parameter int NIB_W     = NIB_W_DEFAULT,
    parameter int LSN_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NIB_W-1:0] out_data,
    output logic             out_en,
    output logic             out_last,
    output logic             busy
);

    // IN_W must be a multiple of NIB_W and hold at least two nibbles.
    localparam int N     = IN_W / NIB_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t state;
    state_t state_d;

    logic [IN_W-1:0]       word_q;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_inc;
    logic [WORD_W_MAX-1:0] in_ext;
    logic [WORD_W_MAX-1:0] word_ext;
    logic [NIB_W-1:0]      nib_first;
    logic [NIB_W-1:0]      nib_next;
    logic                  hs;
    logic                  fire_in;

    // MSN-first selection counts from the top, so left-justify the words.
    assign in_ext   = (LSN_FIRST != 0) ? WORD_W_MAX'(in_data)
                                       : (WORD_W_MAX'(in_data) << (WORD_W_MAX - IN_W));
    assign word_ext = (LSN_FIRST != 0) ? WORD_W_MAX'(word_q)
                                       : (WORD_W_MAX'(word_q) << (WORD_W_MAX - IN_W));

    assign idx_inc   = idx + IDX_W'(1);
    assign nib_first = NIB_W'(nib_sel(in_ext, 0, LSN_FIRST != 0));
    assign nib_next  = NIB_W'(nib_sel(word_ext, 32'(idx_inc), LSN_FIRST != 0));

    assign hs       = out_valid && out_ready;
    // Accepting on the last-nibble handshake is what removes the bubble.
    assign in_ready = !clr && ((state == IDLE) || (hs && out_last));
    assign fire_in  = in_valid && in_ready;
    assign busy     = (state == SEND);
    assign out_en   = out_data[NIB_W-1];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state: flush beats everything, then a new word, then word completion.
    always_comb begin
        state_d = state;
        if (clr) begin
            state_d = IDLE;
        end else if (fire_in) begin
            state_d = SEND;
        end else if (hs && out_last) begin
            state_d = IDLE;
        end
    end

    // Word register, nibble counter and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q    <= '0;
            idx       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (clr) begin
            // out_data is left as-is; it is meaningless while out_valid=0.
            idx       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (fire_in) begin
            word_q    <= in_data;
            idx       <= '0;
            out_data  <= nib_first;
            out_valid <= 1'b1;
            out_last  <= (N == 1);
        end else if (hs && !out_last) begin
            idx      <= idx_inc;
            out_data <= nib_next;
            out_last <= (idx_inc == LAST_IDX);
        end else if (hs && out_last) begin
            idx       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule
